mul_share_arb: RTL and testbench

Round-robin scheduler that shares one pipelined 8x8 multiplier (fixed latency `MUL_LAT`, no stall input) among `N_CH` requesters. It grants at most one operand pair per cycle, drives the multiplier's enable and operand inputs, and tracks the owner of each in-flight product with a tag shift register. It then steers each returning product into a per-channel result register that is held until the requester acknowledges it. The block sits between the requester blocks and the shared multiplier instance.

---
 rtl/mul_share_arb_if.sv | 31 +++
 rtl/mul_share_arb.sv | 138 +++++++++++++
 tb/tb_mul_share_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arb_if.sv
// Requester, result and multiplier-side signals of the shared-multiplier scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic's view.
interface mul_share_arb_if #(
  parameter int size = 8,
  parameter int N_CH = 4
);
  logic [N_CH-1:0]        req_valid;
  logic [N_CH*size-1:0]   req_a;
  logic [N_CH*size-1:0]   req_b;
  logic [N_CH-1:0]        req_ready;
  logic [N_CH-1:0]        res_valid;
  logic [N_CH*2*size-1:0] res_data;
  logic [N_CH-1:0]        res_ack;
  logic                   mul_en_in;
  logic [size-1:0]        mul_a;
  logic [size-1:0]        mul_b;
  logic                   mul_en_out;
  logic [2*size-1:0]      mul_out;
  logic                   busy;
  logic                   err;

  modport slave (
    input  req_valid, req_a, req_b, res_ack, mul_en_out, mul_out,
    output req_ready, res_valid, res_data, mul_en_in, mul_a, mul_b, busy, err
  );

  modport master (
    output req_valid, req_a, req_b, res_ack, mul_en_out, mul_out,
    input  req_ready, res_valid, res_data, mul_en_in, mul_a, mul_b, busy, err
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among N_CH
// requesters; tags follow each issued op so products return to their owner.
module mul_share_arb #(
  parameter int size    = 8,
  parameter int N_CH    = 4,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mul_share_arb_if.slave   bus
);
  localparam int IDW = $clog2(N_CH);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DONE} ch_state_t;

  logic [N_CH-1:0] idle_vec;
  logic [N_CH-1:0] done_vec;
  logic [N_CH-1:0] eligible;
  logic [N_CH-1:0] grant;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  last_q;

  logic            mul_en_q;
  logic [size-1:0] mul_a_q;
  logic [size-1:0] mul_b_q;
  logic [IDW-1:0]  issue_id_q;

  logic            tag_vld_q [MUL_LAT];
  logic [IDW-1:0]  tag_id_q  [MUL_LAT];
  logic            ret_hit;
  logic            mismatch;
  logic            err_q;

  assign eligible = bus.req_valid & idle_vec;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = IDW'((int'(last_q) + k) % N_CH);
      if (!grant_any && eligible[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign bus.req_ready = grant;

  // The issue register is the first pipeline slot; the tag chain then spans the
  // multiplier's own MUL_LAT stages so its tail lines up with mul_en_out.
  assign ret_hit  = bus.mul_en_out && tag_vld_q[MUL_LAT-1];
  assign mismatch = bus.mul_en_out != tag_vld_q[MUL_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= IDW'(N_CH - 1);
      mul_en_q   <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      issue_id_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (grant_any) begin
        last_q <= grant_id;
      end
      mul_en_q   <= grant_any;
      mul_a_q    <= grant_any ? bus.req_a[int'(grant_id)*size +: size] : '0;
      mul_b_q    <= grant_any ? bus.req_b[int'(grant_id)*size +: size] : '0;
      issue_id_q <= grant_id;
      err_q      <= err_q | mismatch;
    end
  end

  generate
    for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q[gi] <= 1'b0;
          tag_id_q[gi]  <= '0;
        end else if (gi == 0) begin
          tag_vld_q[gi] <= mul_en_q;
          tag_id_q[gi]  <= issue_id_q;
        end else begin
          tag_vld_q[gi] <= tag_vld_q[(gi > 0) ? gi - 1 : 0];
          tag_id_q[gi]  <= tag_id_q[(gi > 0) ? gi - 1 : 0];
        end
      end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      ch_state_t         state_q;
      ch_state_t         state_d;
      logic [2*size-1:0] data_q;
      logic              hit;

      assign hit = ret_hit && (tag_id_q[MUL_LAT-1] == IDW'(gi));

      always_comb begin
        state_d = state_q;
        unique case (state_q)
          ST_IDLE: if (grant[gi])       state_d = ST_PEND;
          ST_PEND: if (hit)             state_d = ST_DONE;
          ST_DONE: if (bus.res_ack[gi]) state_d = ST_IDLE;
          default:                      state_d = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          if (hit) begin
            data_q <= bus.mul_out;
          end
        end
      end

      assign idle_vec[gi] = (state_q == ST_IDLE);
      assign done_vec[gi] = (state_q == ST_DONE);
      assign bus.res_data[gi*2*size +: 2*size] = data_q;
    end
  endgenerate

  assign bus.res_valid = done_vec;
  assign bus.mul_en_in = mul_en_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.busy      = ~&idle_vec;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a behavioural pipelined multiplier attached.
module tb_mul_share_arb;
  localparam int SZ  = 8;
  localparam int NCH = 4;
  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  logic force_en;
  logic [NCH-1:0] ack_mask;

  int n_cmp;
  int n_bad;

  mul_share_arb_if #(.size(SZ), .N_CH(NCH)) bus ();

  mul_share_arb #(.size(SZ), .N_CH(NCH), .MUL_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiplier: LAT register stages, flushed by the shared reset.
  logic [LAT-1:0] pv;
  logic [2*SZ-1:0] pp [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int j = 0; j < LAT; j++) pp[j] <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], bus.mul_en_in};
      pp[0] <= bus.mul_a * bus.mul_b;
      for (int j = 1; j < LAT; j++) pp[j] <= pp[j-1];
    end
  end
  assign bus.mul_en_out = pv[LAT-1] | force_en;
  assign bus.mul_out    = pp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.res_ack = bus.res_valid & ack_mask;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rd(input int ch);
    logic [NCH*2*SZ-1:0] v;
    v = bus.res_data;
    return 32'(v[ch*2*SZ +: 2*SZ]);
  endfunction

  task automatic set_op(input int ch, input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    bus.req_a[ch*SZ +: SZ] = a;
    bus.req_b[ch*SZ +: SZ] = b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.res_ack   = '0;
    ack_mask      = '0;
    force_en      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int grants [$];
  int viol;
  int c0_cnt, c1_cnt, unstable;
  logic [31:0] r3;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; force_en = 1'b0; ack_mask = '0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ack = '0;
    do_reset();
    smp();
    chk("rst mul_en_in", 32'(bus.mul_en_in), 0);
    chk("rst mul_a", 32'(bus.mul_a), 0);
    chk("rst res_valid", 32'(bus.res_valid), 0);
    chk("rst res_data", 32'(bus.res_data != '0), 0);
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst err", 32'(bus.err), 0);

    // Single op: ch0 13*11 granted in cycle 0
    cyc();
    set_op(0, 8'd13, 8'd11);
    bus.req_valid = 4'b0001;
    smp();
    chk("single ready c0", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = '0;
    smp();
    chk("single en_in c1", 32'(bus.mul_en_in), 1);
    chk("single mul_a c1", 32'(bus.mul_a), 13);
    chk("single mul_b c1", 32'(bus.mul_b), 11);
    chk("single busy c1", 32'(bus.busy), 1);
    for (int i = 2; i <= 5; i++) cyc();
    smp();
    chk("single valid c5", 32'(bus.res_valid), 0);
    cyc();
    smp();
    chk("single valid c6", 32'(bus.res_valid), 32'h1);
    chk("single data c6", rd(0), 143);
    for (int i = 0; i < 4; i++) cyc();
    smp();
    chk("single held", rd(0) | (32'(bus.res_valid) << 16), 32'h1_008F);
    cyc();
    bus.res_ack = 4'b0001;
    cyc();
    bus.res_ack = '0;
    smp();
    chk("single valid after ack", 32'(bus.res_valid), 0);
    chk("single busy after ack", 32'(bus.busy), 0);

    // Back-to-back: ch1 255*255 then ch2 0*77 (last grant is ch0)
    cyc();
    set_op(1, 8'd255, 8'd255);
    set_op(2, 8'd0, 8'd77);
    bus.req_valid = 4'b0110;
    smp();
    chk("b2b ready c0", 32'(bus.req_ready), 32'h2);
    cyc();
    smp();
    chk("b2b ready c1", 32'(bus.req_ready), 32'h4);
    chk("b2b mul_a c1", 32'(bus.mul_a), 255);
    cyc();
    bus.req_valid = '0;
    smp();
    chk("b2b mul_b c2", 32'(bus.mul_b), 77);
    for (int i = 3; i <= 6; i++) cyc();
    smp();
    chk("b2b valid c6", 32'(bus.res_valid), 32'h2);
    chk("b2b data1 c6", rd(1), 32'hFE01);
    cyc();
    smp();
    chk("b2b valid c7", 32'(bus.res_valid), 32'h6);
    chk("b2b data2 c7", rd(2), 0);

    // Fairness: all channels request, a=i+1, b=255, immediate acks
    do_reset();
    for (int i = 0; i < NCH; i++) set_op(i, SZ'(i + 1), 8'd255);
    bus.req_valid = '1;
    ack_mask = '1;
    viol = 0;
    r3 = '0;
    grants.delete();
    for (int c = 0; c < 40; c++) begin
      smp();
      if (!$onehot(bus.req_ready)) begin
        if (bus.req_ready != '0) viol++;
      end else begin
        for (int i = 0; i < NCH; i++) if (bus.req_ready[i]) grants.push_back(i);
      end
      if (bus.res_valid[3]) r3 = rd(3);
      cyc();
    end
    bus.req_valid = '0;
    chk("fair onehot", 32'(viol), 0);
    chk("fair count>=8", 32'(grants.size() >= 8), 1);
    if (grants.size() >= 8) begin
      chk("fair order", 32'({grants[0][3:0], grants[1][3:0], grants[2][3:0], grants[3][3:0],
                             grants[4][3:0], grants[5][3:0], grants[6][3:0], grants[7][3:0]}),
          32'h01230123);
    end
    viol = 0;
    for (int j = 0; j + 3 < grants.size(); j++)
      for (int p = j; p < j + 4; p++)
        for (int q = p + 1; q < j + 4; q++)
          if (grants[p] == grants[q]) viol++;
    chk("fair window", 32'(viol), 0);
    chk("fair ch3 data", r3, 1020);

    // Held result: ch0 never acks, ch1 keeps going
    do_reset();
    set_op(0, 8'd7, 8'd9);
    set_op(1, 8'd2, 8'd3);
    bus.req_valid = 4'b0011;
    ack_mask = 4'b0010;
    c0_cnt = 0; c1_cnt = 0; unstable = 0;
    for (int c = 0; c < 27; c++) begin
      smp();
      if (bus.req_ready[0]) c0_cnt++;
      if (c >= 7) begin
        if (bus.req_ready[1]) c1_cnt++;
        if (rd(0) != 63 || !bus.res_valid[0]) unstable++;
      end
      cyc();
    end
    bus.req_valid = '0;
    chk("held ch0 grants", 32'(c0_cnt), 1);
    chk("held ch0 stable", 32'(unstable), 0);
    chk("held ch1 progress", 32'(c1_cnt >= 2), 1);

    // Reset mid-flight after two grants
    do_reset();
    set_op(0, 8'd5, 8'd5);
    set_op(1, 8'd6, 8'd6);
    bus.req_valid = 4'b0011;
    cyc();
    cyc();
    bus.req_valid = '0;
    cyc();
    rst_n = 1'b0;
    smp();
    chk("midrst en_in", 32'(bus.mul_en_in), 0);
    chk("midrst busy", 32'(bus.busy), 0);
    chk("midrst mul_a", 32'(bus.mul_a), 0);
    cyc();
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (bus.res_valid != '0 || bus.err) viol++;
      cyc();
    end
    chk("midrst no result/err", 32'(viol), 0);

    // Mismatch: spurious mul_en_out with nothing in flight
    force_en = 1'b1;
    smp();
    chk("mism err same cycle", 32'(bus.err), 0);
    cyc();
    force_en = 1'b0;
    smp();
    chk("mism err next", 32'(bus.err), 1);
    cyc();
    cyc();
    smp();
    chk("mism err sticky", 32'(bus.err), 1);
    chk("mism res_valid", 32'(bus.res_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
